// File: rtl/traffic_phase_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_scheduler_if
// Purpose  : Control, button and lamp/status bundle of the two-approach
//            intersection phase scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface traffic_phase_scheduler_if;
   logic       en;
   logic [3:0] btn;
   logic       led4_r;
   logic       led4_g;
   logic       led4_b;
   logic       led5_r;
   logic       led5_g;
   logic       led5_b;
   logic [3:0] cnt;
   logic [2:0] phase;

   // Board / environment side: drives enable and buttons, observes lamps.
   modport master (
      output en, btn,
      input  led4_r, led4_g, led4_b, led5_r, led5_g, led5_b, cnt, phase
   );

   // Scheduler side.
   modport slave (
      input  en, btn,
      output led4_r, led4_g, led4_b, led5_r, led5_g, led5_b, cnt, phase
   );
endinterface
`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_scheduler
// Purpose  : Board-level lamp sequencer for a two-approach intersection.
//            Cycles A green/yellow, all-red, B green/yellow, all-red with
//            demand truncation, green hold and emergency all-red.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_scheduler #(
   parameter int TICK_DIV  = 4,
   parameter int GREEN_T   = 5,
   parameter int YELLOW_T  = 2,
   parameter int ALL_RED_T = 1,
   parameter int MIN_GREEN = 2
) (
   input  wire logic                 clk,
   input  wire logic                 rst_n,
   traffic_phase_scheduler_if.slave  bus
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
   localparam logic [3:0]    GREEN_LD  = 4'(GREEN_T - 1);
   localparam logic [3:0]    YELLOW_LD = 4'(YELLOW_T - 1);
   localparam logic [3:0]    AR_LD     = 4'(ALL_RED_T - 1);
   // Largest remaining count at which a demand may cut a green short.
   localparam logic [3:0]    TRUNC_MAX = 4'(GREEN_T - MIN_GREEN);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      A_GREEN   = 3'd1,
      A_YELLOW  = 3'd2,
      ALL_RED_1 = 3'd3,
      B_GREEN   = 3'd4,
      B_YELLOW  = 3'd5,
      EMERG     = 3'd6,
      ALL_RED_2 = 3'd7
   } state_t;

   state_t        state, state_n;
   logic [3:0]    cnt, cnt_n;
   logic [PW-1:0] presc, presc_n;
   logic          pend_a, pend_a_n;
   logic          pend_b, pend_b_n;
   logic          tick;
   logic          hold;
   logic          emerg_req;
   logic          cnt_zero;

   assign tick      = (presc == PRE_MAX) && bus.en;
   assign hold      = bus.btn[2];
   assign emerg_req = bus.btn[3] && (state != IDLE);
   assign cnt_zero  = (cnt == 4'd0);

   // State, phase counter, prescaler and demand latches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         presc  <= '0;
         pend_a <= 1'b0;
         pend_b <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         presc  <= presc_n;
         pend_a <= pend_a_n;
         pend_b <= pend_b_n;
      end
   end

   // Next-state: emergency overrides freeze, which overrides phase timing.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      presc_n  = presc;
      pend_a_n = pend_a;
      pend_b_n = pend_b;

      if (emerg_req) begin
         state_n = EMERG;
         cnt_n   = 4'd0;
         presc_n = '0;
      end else if (bus.en) begin
         // Idle/emergency keep the prescaler parked so the next phase starts tick-aligned.
         if (state == IDLE || state == EMERG)
            presc_n = '0;
         else if (presc == PRE_MAX)
            presc_n = '0;
         else
            presc_n = presc + 1'b1;

         case (state)
            IDLE, EMERG: begin
               state_n = ALL_RED_2;
               cnt_n   = AR_LD;
            end
            A_GREEN: begin
               if (!hold && tick) begin
                  if (cnt_zero || (pend_b && cnt <= TRUNC_MAX)) begin
                     state_n = A_YELLOW;
                     cnt_n   = YELLOW_LD;
                  end else begin
                     cnt_n = cnt - 1'b1;
                  end
               end
            end
            A_YELLOW: begin
               if (tick) begin
                  if (cnt_zero) begin
                     state_n = ALL_RED_1;
                     cnt_n   = AR_LD;
                  end else begin
                     cnt_n = cnt - 1'b1;
                  end
               end
            end
            ALL_RED_1: begin
               if (tick) begin
                  if (cnt_zero) begin
                     state_n = B_GREEN;
                     cnt_n   = GREEN_LD;
                  end else begin
                     cnt_n = cnt - 1'b1;
                  end
               end
            end
            B_GREEN: begin
               if (!hold && tick) begin
                  if (cnt_zero || (pend_a && cnt <= TRUNC_MAX)) begin
                     state_n = B_YELLOW;
                     cnt_n   = YELLOW_LD;
                  end else begin
                     cnt_n = cnt - 1'b1;
                  end
               end
            end
            B_YELLOW: begin
               if (tick) begin
                  if (cnt_zero) begin
                     state_n = ALL_RED_2;
                     cnt_n   = AR_LD;
                  end else begin
                     cnt_n = cnt - 1'b1;
                  end
               end
            end
            ALL_RED_2: begin
               if (tick) begin
                  if (cnt_zero) begin
                     state_n = A_GREEN;
                     cnt_n   = GREEN_LD;
                  end else begin
                     cnt_n = cnt - 1'b1;
                  end
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = 4'd0;
            end
         endcase

         // A demand arriving on the entry cycle of its own green survives the clear.
         pend_a_n = (((state_n == A_GREEN) && (state != A_GREEN)) ? 1'b0 : pend_a) | bus.btn[0];
         pend_b_n = (((state_n == B_GREEN) && (state != B_GREEN)) ? 1'b0 : pend_b) | bus.btn[1];
      end
   end

   // Lamp decode from the registered state (yellow = red + green, blue unused).
   always_comb begin
      bus.led4_r = 1'b0;
      bus.led4_g = 1'b0;
      bus.led5_r = 1'b0;
      bus.led5_g = 1'b0;
      case (state)
         A_GREEN: begin
            bus.led4_g = 1'b1;
            bus.led5_r = 1'b1;
         end
         A_YELLOW: begin
            bus.led4_r = 1'b1;
            bus.led4_g = 1'b1;
            bus.led5_r = 1'b1;
         end
         B_GREEN: begin
            bus.led4_r = 1'b1;
            bus.led5_g = 1'b1;
         end
         B_YELLOW: begin
            bus.led4_r = 1'b1;
            bus.led5_r = 1'b1;
            bus.led5_g = 1'b1;
         end
         ALL_RED_1, ALL_RED_2, EMERG: begin
            bus.led4_r = 1'b1;
            bus.led5_r = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.led4_b = 1'b0;
   assign bus.led5_b = 1'b0;
   assign bus.cnt    = cnt;
   assign bus.phase  = state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_scheduler
// Purpose  : Directed self-checking bench for traffic_phase_scheduler with
//            TICK_DIV=4, GREEN_T=5, YELLOW_T=2, ALL_RED_T=1, MIN_GREEN=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_scheduler;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   traffic_phase_scheduler_if bus ();

   traffic_phase_scheduler #(
      .TICK_DIV  (4),
      .GREEN_T   (5),
      .YELLOW_T  (2),
      .ALL_RED_T (1),
      .MIN_GREEN (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Lamps packed as {led4 rgb, led5 rgb}.
   logic [5:0] lamps;
   assign lamps = {bus.led4_r, bus.led4_g, bus.led4_b, bus.led5_r, bus.led5_g, bus.led5_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Step until the phase output equals p, within a cycle budget.
   task automatic wait_phase(input logic [2:0] p, output bit ok);
      int n;
      n  = 0;
      ok = 1'b1;
      while (bus.phase !== p && n < 200) begin
         step();
         n++;
      end
      if (bus.phase !== p) ok = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2;
      rst_n   = 1'b0;
      bus.en  = 1'b0;
      bus.btn = 4'd0;
      repeat (3) step();
      vectors++;
      if (bus.phase !== 3'd0 || bus.cnt !== 4'd0 || lamps !== 6'b000_000) begin
         miscompares++;
         $display("FAIL reset_state: phase=%0d cnt=%0d lamps=%b, required phase=0 cnt=0 lamps=000000",
                  bus.phase, bus.cnt, lamps);
      end
      rst_n  = 1'b1;
      bus.en = 1'b1;
      step();
      vectors++;
      if (bus.phase !== 3'd7 || lamps !== 6'b100_100) begin
         miscompares++;
         $display("FAIL reset_release_c1: phase=%0d lamps=%b, required phase=7 lamps=100100",
                  bus.phase, lamps);
      end
      repeat (4) step();
      vectors++;
      if (bus.phase !== 3'd1 || bus.cnt !== 4'd4 || lamps !== 6'b010_100) begin
         miscompares++;
         $display("FAIL reset_release_c5: phase=%0d cnt=%0d lamps=%b, required phase=1 cnt=4 lamps=010100",
                  bus.phase, bus.cnt, lamps);
      end
   endtask

   task automatic test_free_run();
      logic [2:0] ph  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
      int         len [6] = '{20, 8, 4, 20, 8, 4};
      logic [3:0] c0  [6] = '{4'd4, 4'd1, 4'd0, 4'd4, 4'd1, 4'd0};
      logic [5:0] lmp [6] = '{6'b010_100, 6'b110_100, 6'b100_100,
                              6'b100_010, 6'b100_110, 6'b100_100};
      int n;
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (bus.phase !== ph[i] || bus.cnt !== c0[i] || lamps !== lmp[i]) begin
            miscompares++;
            $display("FAIL free_run_entry[%0d]: phase=%0d cnt=%0d lamps=%b, required phase=%0d cnt=%0d lamps=%b",
                     i, bus.phase, bus.cnt, lamps, ph[i], c0[i], lmp[i]);
         end
         n = 0;
         while (bus.phase === ph[i] && n < 100) begin
            n++;
            step();
         end
         vectors++;
         if (n != len[i]) begin
            miscompares++;
            $display("FAIL free_run_len[%0d]: phase %0d lasted %0d cycles, required %0d",
                     i, ph[i], n, len[i]);
         end
      end
      vectors++;
      if (bus.phase !== 3'd1 || bus.cnt !== 4'd4) begin
         miscompares++;
         $display("FAIL free_run_wrap: phase=%0d cnt=%0d, required phase=1 cnt=4", bus.phase, bus.cnt);
      end
   endtask

   // Entered on the first cycle of A_GREEN.
   task automatic test_truncate();
      int n;
      bit ok;
      bus.btn = 4'b0010;
      step();
      bus.btn = 4'b0000;
      n = 1;
      while (bus.phase === 3'd1 && n < 100) begin
         n++;
         step();
      end
      vectors++;
      if (n != 8 || bus.phase !== 3'd2) begin
         miscompares++;
         $display("FAIL truncate_len: A_GREEN lasted %0d cycles then phase=%0d, required 8 then phase=2",
                  n, bus.phase);
      end
      vectors++;
      if (dut.pend_b !== 1'b1) begin
         miscompares++;
         $display("FAIL truncate_pend_b_held: pend_b=%0b, required 1", dut.pend_b);
      end
      wait_phase(3'd4, ok);
      vectors++;
      if (!ok || dut.pend_b !== 1'b0) begin
         miscompares++;
         $display("FAIL truncate_pend_b_clear: reached=%0b pend_b=%0b, required reached=1 pend_b=0",
                  ok, dut.pend_b);
      end
   endtask

   // Entered on the first cycle of B_GREEN.
   task automatic test_hold();
      int n;
      bit ok;
      repeat (8) step();
      vectors++;
      if (bus.phase !== 3'd4 || bus.cnt !== 4'd2) begin
         miscompares++;
         $display("FAIL hold_pre: phase=%0d cnt=%0d, required phase=4 cnt=2", bus.phase, bus.cnt);
      end
      bus.btn = 4'b0100;
      for (int i = 0; i < 12; i++) begin
         step();
         vectors++;
         if (bus.phase !== 3'd4 || bus.cnt !== 4'd2) begin
            miscompares++;
            $display("FAIL hold_green[%0d]: phase=%0d cnt=%0d, required phase=4 cnt=2",
                     i, bus.phase, bus.cnt);
         end
      end
      bus.btn = 4'b0000;
      n = 20;
      while (bus.phase === 3'd4 && n < 100) begin
         n++;
         step();
      end
      vectors++;
      if (n != 32) begin
         miscompares++;
         $display("FAIL hold_green_len: B_GREEN lasted %0d cycles, required 32", n);
      end
      wait_phase(3'd2, ok);
      bus.btn = 4'b0100;
      n = 0;
      while (bus.phase === 3'd2 && n < 100) begin
         n++;
         step();
      end
      bus.btn = 4'b0000;
      vectors++;
      if (!ok || n != 8) begin
         miscompares++;
         $display("FAIL hold_yellow_len: reached=%0b A_YELLOW lasted %0d cycles, required 8", ok, n);
      end
   endtask

   task automatic test_emergency();
      int n;
      bit ok;
      wait_phase(3'd2, ok);
      repeat (3) step();
      bus.btn = 4'b1000;
      step();
      vectors++;
      if (!ok || bus.phase !== 3'd6 || bus.cnt !== 4'd0 || lamps !== 6'b100_100) begin
         miscompares++;
         $display("FAIL emerg_entry: phase=%0d cnt=%0d lamps=%b, required phase=6 cnt=0 lamps=100100",
                  bus.phase, bus.cnt, lamps);
      end
      repeat (3) step();
      vectors++;
      if (bus.phase !== 3'd6) begin
         miscompares++;
         $display("FAIL emerg_stay: phase=%0d, required 6", bus.phase);
      end
      bus.btn = 4'b0000;
      step();
      n = 0;
      while (bus.phase === 3'd7 && n < 100) begin
         n++;
         step();
      end
      vectors++;
      if (n != 4 || bus.phase !== 3'd1 || bus.cnt !== 4'd4) begin
         miscompares++;
         $display("FAIL emerg_exit: all-red %0d cycles then phase=%0d cnt=%0d, required 4 then phase=1 cnt=4",
                  n, bus.phase, bus.cnt);
      end
   endtask

   // Entered on the first cycle of A_GREEN.
   task automatic test_en_freeze();
      int n;
      repeat (5) step();
      vectors++;
      if (bus.phase !== 3'd1 || bus.cnt !== 4'd3) begin
         miscompares++;
         $display("FAIL freeze_pre: phase=%0d cnt=%0d, required phase=1 cnt=3", bus.phase, bus.cnt);
      end
      bus.en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         vectors++;
         if (bus.phase !== 3'd1 || bus.cnt !== 4'd3) begin
            miscompares++;
            $display("FAIL freeze_hold[%0d]: phase=%0d cnt=%0d, required phase=1 cnt=3",
                     i, bus.phase, bus.cnt);
         end
      end
      bus.en = 1'b1;
      n = 15;
      while (bus.phase === 3'd1 && n < 100) begin
         n++;
         step();
      end
      vectors++;
      if (n != 30) begin
         miscompares++;
         $display("FAIL freeze_len: A_GREEN lasted %0d cycles, required 30", n);
      end
   endtask

   // Demand held across the edge into B_GREEN must stay latched.
   task automatic test_set_wins();
      bit ok;
      wait_phase(3'd3, ok);
      bus.btn = 4'b0010;
      wait_phase(3'd4, ok);
      bus.btn = 4'b0000;
      vectors++;
      if (!ok || dut.pend_b !== 1'b1) begin
         miscompares++;
         $display("FAIL set_wins: reached=%0b pend_b=%0b, required reached=1 pend_b=1", ok, dut.pend_b);
      end
   endtask

   // Entered inside B_GREEN.
   task automatic test_reset_mid();
      bus.btn = 4'b0001;
      step();
      bus.btn = 4'b0000;
      vectors++;
      if (dut.pend_a !== 1'b1 || bus.phase !== 3'd4) begin
         miscompares++;
         $display("FAIL reset_mid_pre: pend_a=%0b phase=%0d, required pend_a=1 phase=4",
                  dut.pend_a, bus.phase);
      end
      repeat (2) step();
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.phase !== 3'd0 || bus.cnt !== 4'd0 || lamps !== 6'b000_000 || dut.pend_a !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: phase=%0d cnt=%0d lamps=%b pend_a=%0b, required 0 0 000000 0",
                  bus.phase, bus.cnt, lamps, dut.pend_a);
      end
      repeat (2) step();
      rst_n = 1'b1;
      step();
      vectors++;
      if (bus.phase !== 3'd7) begin
         miscompares++;
         $display("FAIL reset_mid_restart: phase=%0d, required 7", bus.phase);
      end
   endtask

   initial begin
      bit ok;
      vectors     = 0;
      miscompares = 0;
      bus.en      = 1'b0;
      bus.btn     = 4'd0;
      test_reset();
      test_free_run();
      test_truncate();
      test_hold();
      test_emergency();
      test_en_freeze();
      test_set_wins();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
